// File: rtl/forwarding_unit_r1.sv
// Operand forwarding and load-hazard unit: picks each ALU operand from the register file,
// the EX/WB ALU result or returning load data, and tracks outstanding loads in order.
module forwarding_unit_r1 #(
  parameter int ADDR_WIDTH  = 5,
  parameter int DATA_WIDTH  = 32,
  parameter int MAX_PENDING = 4,
  localparam int CNT_W = $clog2(MAX_PENDING + 1),
  localparam int PTR_W = (MAX_PENDING > 1) ? $clog2(MAX_PENDING) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_id_ex_valid,
  input  logic [ADDR_WIDTH-1:0] i_id_ex_rs,
  input  logic [ADDR_WIDTH-1:0] i_id_ex_rt,
  input  logic                  i_id_ex_rs_used,
  input  logic                  i_id_ex_rt_used,
  input  logic [ADDR_WIDTH-1:0] i_id_ex_rd,
  input  logic                  i_id_ex_regwrite,
  input  logic                  i_id_ex_memtoreg,
  input  logic [DATA_WIDTH-1:0] i_id_ex_rs_data,
  input  logic [DATA_WIDTH-1:0] i_id_ex_rt_data,
  input  logic                  i_ex_wb_valid,
  input  logic                  i_ex_wb_regwrite,
  input  logic                  i_ex_wb_memtoreg,
  input  logic [ADDR_WIDTH-1:0] i_ex_wb_rd,
  input  logic [DATA_WIDTH-1:0] i_ex_wb_result,
  input  logic                  i_mem_data_valid,
  input  logic [DATA_WIDTH-1:0] i_mem_data,
  output logic [DATA_WIDTH-1:0] o_operand_a,
  output logic [DATA_WIDTH-1:0] o_operand_b,
  output logic [1:0]            o_forward_a,
  output logic [1:0]            o_forward_b,
  output logic                  o_stall,
  output logic                  o_load_wb_valid,
  output logic [ADDR_WIDTH-1:0] o_load_wb_rd,
  output logic [DATA_WIDTH-1:0] o_load_wb_data,
  output logic [CNT_W-1:0]      o_pending_count,
  output logic                  o_err_underflow,
  output logic                  o_err_overflow
);

  logic [ADDR_WIDTH-1:0] r_fifo [MAX_PENDING];
  logic [PTR_W-1:0]      r_head;
  logic [PTR_W-1:0]      r_tail;
  logic [CNT_W-1:0]      r_count;
  logic                  r_err_underflow;
  logic                  r_err_overflow;

  logic                   w_empty;
  logic                   w_full;
  logic                   w_push_req;
  logic                   w_push;
  logic                   w_pop;
  logic [ADDR_WIDTH-1:0]  w_head_rd;
  logic [MAX_PENDING-1:0] w_live;
  logic                   w_rs_hit;
  logic                   w_rt_hit;
  logic                   w_rd_hit;
  logic                   w_slots_full;
  logic                   w_alu_a;
  logic                   w_alu_b;
  logic                   w_mem_a;
  logic                   w_mem_b;
  logic [1:0]             w_fwd_a;
  logic [1:0]             w_fwd_b;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(MAX_PENDING - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == CNT_W'(MAX_PENDING));
  assign w_push_req = i_ex_wb_valid & i_ex_wb_regwrite & i_ex_wb_memtoreg;
  assign w_pop      = i_mem_data_valid & ~w_empty;
  assign w_push     = w_push_req & (~w_full | w_pop);
  assign w_head_rd  = r_fifo[r_head];

  // An entry is live when it lies within count of the head; the head stops counting once popped.
  always_comb begin
    int rel;
    rel    = 0;
    w_live = '0;
    for (int i = 0; i < MAX_PENDING; i++) begin
      if (i >= int'(r_head)) rel = i - int'(r_head);
      else                   rel = i + MAX_PENDING - int'(r_head);
      w_live[i] = (rel < int'(r_count)) && !(w_pop && (rel == 0));
    end
  end

  always_comb begin
    w_rs_hit = w_push_req && (i_ex_wb_rd == i_id_ex_rs);
    w_rt_hit = w_push_req && (i_ex_wb_rd == i_id_ex_rt);
    w_rd_hit = w_push_req && (i_ex_wb_rd == i_id_ex_rd);
    for (int i = 0; i < MAX_PENDING; i++) begin
      if (w_live[i] && (r_fifo[i] == i_id_ex_rs)) w_rs_hit = 1'b1;
      if (w_live[i] && (r_fifo[i] == i_id_ex_rt)) w_rt_hit = 1'b1;
      if (w_live[i] && (r_fifo[i] == i_id_ex_rd)) w_rd_hit = 1'b1;
    end
  end

  assign w_slots_full =
      (int'(r_count) + int'(w_push_req) - int'(w_pop)) >= MAX_PENDING;

  assign w_alu_a = i_ex_wb_valid & i_ex_wb_regwrite & ~i_ex_wb_memtoreg &
                   (i_ex_wb_rd != '0) & (i_ex_wb_rd == i_id_ex_rs);
  assign w_alu_b = i_ex_wb_valid & i_ex_wb_regwrite & ~i_ex_wb_memtoreg &
                   (i_ex_wb_rd != '0) & (i_ex_wb_rd == i_id_ex_rt);
  assign w_mem_a = w_pop & (w_head_rd != '0) & (w_head_rd == i_id_ex_rs);
  assign w_mem_b = w_pop & (w_head_rd != '0) & (w_head_rd == i_id_ex_rt);

  always_comb begin
    w_fwd_a = 2'b00;
    w_fwd_b = 2'b00;
    if (!i_rst) begin
      if (w_alu_a)      w_fwd_a = 2'b01;
      else if (w_mem_a) w_fwd_a = 2'b10;
      if (w_alu_b)      w_fwd_b = 2'b01;
      else if (w_mem_b) w_fwd_b = 2'b10;
    end
  end

  always_comb begin
    case (w_fwd_a)
      2'b01:   o_operand_a = i_ex_wb_result;
      2'b10:   o_operand_a = i_mem_data;
      default: o_operand_a = i_id_ex_rs_data;
    endcase
    case (w_fwd_b)
      2'b01:   o_operand_b = i_ex_wb_result;
      2'b10:   o_operand_b = i_mem_data;
      default: o_operand_b = i_id_ex_rt_data;
    endcase
  end

  assign o_forward_a = w_fwd_a;
  assign o_forward_b = w_fwd_b;

  assign o_stall = ~i_rst & i_id_ex_valid & (
      (i_id_ex_rs_used  & (i_id_ex_rs != '0) & w_rs_hit) |
      (i_id_ex_rt_used  & (i_id_ex_rt != '0) & w_rt_hit) |
      (i_id_ex_regwrite & (i_id_ex_rd != '0) & w_rd_hit) |
      (i_id_ex_memtoreg & w_slots_full));

  assign o_load_wb_valid = w_pop & ~i_rst;
  assign o_load_wb_rd    = o_load_wb_valid ? w_head_rd : '0;
  assign o_load_wb_data  = i_rst ? '0 : i_mem_data;
  assign o_pending_count = r_count;
  assign o_err_underflow = r_err_underflow;
  assign o_err_overflow  = r_err_overflow;

  always_ff @(posedge i_clk) begin
    if (!i_rst && w_push) r_fifo[r_tail] <= i_ex_wb_rd;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_head          <= '0;
      r_tail          <= '0;
      r_count         <= '0;
      r_err_underflow <= 1'b0;
      r_err_overflow  <= 1'b0;
    end else begin
      if (w_push) r_tail <= ptr_inc(r_tail);
      if (w_pop)  r_head <= ptr_inc(r_head);
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
      if (i_mem_data_valid && w_empty)        r_err_underflow <= 1'b1;
      if (w_push_req && w_full && !w_pop)     r_err_overflow  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_forwarding_unit_r1.sv
// Scoreboard bench for forwarding_unit_r1: directed hazard scenarios followed by random traffic,
// each cycle checked against a queue-based model of the outstanding-load list.
module tb_forwarding_unit_r1;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int MP = 4;
  localparam int CW = $clog2(MP + 1);

  typedef struct {
    logic          rst, idv, rsu, rtu, rw, mtr;
    logic [AW-1:0] rs, rt, rd;
    logic [DW-1:0] rsd, rtd;
    logic          wbv, wbrw, wbm;
    logic [AW-1:0] wbrd;
    logic [DW-1:0] wbres;
    logic          mdv;
    logic [DW-1:0] md;
  } stim_t;

  typedef struct {
    logic [DW-1:0] opa, opb;
    logic [1:0]    fa, fb;
    logic          stall, lwv;
    logic [AW-1:0] lwrd;
    logic [DW-1:0] lwd;
    logic [CW-1:0] cnt;
    logic          eu, eo;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst, id_ex_valid, id_ex_rs_used, id_ex_rt_used, id_ex_regwrite, id_ex_memtoreg;
  logic [AW-1:0] id_ex_rs, id_ex_rt, id_ex_rd, ex_wb_rd;
  logic [DW-1:0] id_ex_rs_data, id_ex_rt_data, ex_wb_result, mem_data;
  logic          ex_wb_valid, ex_wb_regwrite, ex_wb_memtoreg, mem_data_valid;
  logic [DW-1:0] operand_a, operand_b, load_wb_data;
  logic [1:0]    forward_a, forward_b;
  logic          stall, load_wb_valid, err_underflow, err_overflow;
  logic [AW-1:0] load_wb_rd;
  logic [CW-1:0] pending_count;

  exp_t          expq[$];
  logic [AW-1:0] pend[$];
  bit            m_eu, m_eo;
  int            vectors = 0;
  int            miscompares = 0;

  always #5 clk = ~clk;

  forwarding_unit_r1 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_PENDING(MP)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_id_ex_valid(id_ex_valid), .i_id_ex_rs(id_ex_rs), .i_id_ex_rt(id_ex_rt),
    .i_id_ex_rs_used(id_ex_rs_used), .i_id_ex_rt_used(id_ex_rt_used),
    .i_id_ex_rd(id_ex_rd), .i_id_ex_regwrite(id_ex_regwrite),
    .i_id_ex_memtoreg(id_ex_memtoreg),
    .i_id_ex_rs_data(id_ex_rs_data), .i_id_ex_rt_data(id_ex_rt_data),
    .i_ex_wb_valid(ex_wb_valid), .i_ex_wb_regwrite(ex_wb_regwrite),
    .i_ex_wb_memtoreg(ex_wb_memtoreg), .i_ex_wb_rd(ex_wb_rd), .i_ex_wb_result(ex_wb_result),
    .i_mem_data_valid(mem_data_valid), .i_mem_data(mem_data),
    .o_operand_a(operand_a), .o_operand_b(operand_b),
    .o_forward_a(forward_a), .o_forward_b(forward_b), .o_stall(stall),
    .o_load_wb_valid(load_wb_valid), .o_load_wb_rd(load_wb_rd), .o_load_wb_data(load_wb_data),
    .o_pending_count(pending_count),
    .o_err_underflow(err_underflow), .o_err_overflow(err_overflow)
  );

  function automatic bit is_pend(logic [AW-1:0] r, bit pop, bit preq, logic [AW-1:0] wbrd);
    if (r == 0) return 1'b0;
    for (int i = (pop ? 1 : 0); i < pend.size(); i++) if (pend[i] == r) return 1'b1;
    return preq && (wbrd == r);
  endfunction

  function automatic logic [1:0] fwd(stim_t s, logic [AW-1:0] x, bit pop);
    if (s.wbv && s.wbrw && !s.wbm && s.wbrd != 0 && s.wbrd == x) return 2'b01;
    if (pop && pend[0] != 0 && pend[0] == x) return 2'b10;
    return 2'b00;
  endfunction

  function automatic stim_t idle();
    stim_t s = '{default: '0};
    return s;
  endfunction

  task automatic apply(input stim_t s);
    exp_t e;
    bit   pop, preq;
    int   n;
    @(posedge clk);
    #1;
    rst = s.rst; id_ex_valid = s.idv; id_ex_rs = s.rs; id_ex_rt = s.rt; id_ex_rd = s.rd;
    id_ex_rs_used = s.rsu; id_ex_rt_used = s.rtu; id_ex_regwrite = s.rw;
    id_ex_memtoreg = s.mtr; id_ex_rs_data = s.rsd; id_ex_rt_data = s.rtd;
    ex_wb_valid = s.wbv; ex_wb_regwrite = s.wbrw; ex_wb_memtoreg = s.wbm;
    ex_wb_rd = s.wbrd; ex_wb_result = s.wbres; mem_data_valid = s.mdv; mem_data = s.md;
    n    = pend.size();
    preq = s.wbv && s.wbrw && s.wbm;
    pop  = !s.rst && s.mdv && n > 0;
    e.cnt = CW'(n);
    e.eu  = m_eu;
    e.eo  = m_eo;
    if (s.rst) begin
      e.fa = 2'b00; e.fb = 2'b00; e.stall = 1'b0; e.lwv = 1'b0; e.lwrd = '0; e.lwd = '0;
    end else begin
      e.fa    = fwd(s, s.rs, pop);
      e.fb    = fwd(s, s.rt, pop);
      e.stall = s.idv && ((s.rsu && is_pend(s.rs, pop, preq, s.wbrd)) ||
                          (s.rtu && is_pend(s.rt, pop, preq, s.wbrd)) ||
                          (s.rw  && is_pend(s.rd, pop, preq, s.wbrd)) ||
                          (s.mtr && (n + int'(preq) - int'(pop) >= MP)));
      e.lwv   = pop;
      e.lwrd  = pop ? pend[0] : '0;
      e.lwd   = s.md;
    end
    e.opa = (e.fa == 2'b01) ? s.wbres : (e.fa == 2'b10) ? s.md : s.rsd;
    e.opb = (e.fb == 2'b01) ? s.wbres : (e.fb == 2'b10) ? s.md : s.rtd;
    expq.push_back(e);
    if (s.rst) begin
      pend.delete();
      m_eu = 1'b0;
      m_eo = 1'b0;
    end else begin
      if (s.mdv && n == 0) m_eu = 1'b1;
      if (pop) void'(pend.pop_front());
      if (preq) begin
        if (n == MP && !pop) m_eo = 1'b1;
        else pend.push_back(s.wbrd);
      end
    end
  endtask

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s vector %0d: got 0x%0h, want 0x%0h", name, vectors, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        vectors++;
        chk("operand_a", operand_a, e.opa);
        chk("operand_b", operand_b, e.opb);
        chk("forward_a", DW'(forward_a), DW'(e.fa));
        chk("forward_b", DW'(forward_b), DW'(e.fb));
        chk("stall", DW'(stall), DW'(e.stall));
        chk("load_wb_valid", DW'(load_wb_valid), DW'(e.lwv));
        chk("load_wb_rd", DW'(load_wb_rd), DW'(e.lwrd));
        chk("load_wb_data", load_wb_data, e.lwd);
        chk("pending_count", DW'(pending_count), DW'(e.cnt));
        chk("err_underflow", DW'(err_underflow), DW'(e.eu));
        chk("err_overflow", DW'(err_overflow), DW'(e.eo));
      end
    end
  end

  task automatic ld_push(input logic [AW-1:0] r, inout stim_t s);
    s.wbv = 1'b1; s.wbrw = 1'b1; s.wbm = 1'b1; s.wbrd = r;
  endtask

  initial begin : stimulus
    stim_t s;
    rst = 1'b1;
    s = idle(); s.rst = 1'b1;
    apply(s); apply(s);

    // ALU forward, then the same with rd = r0
    s = idle(); s.idv = 1; s.rs = 3; s.rsu = 1; s.rsd = 32'h1111;
    s.wbv = 1; s.wbrw = 1; s.wbrd = 3; s.wbres = 32'h1234;
    apply(s);
    s.rs = 0; s.wbrd = 0;
    apply(s);

    // Load-use on r5 resolved by a memory return of 0xBEEF
    s = idle(); s.idv = 1; s.rt = 5; s.rtu = 1; s.rtd = 32'h5555;
    ld_push(5, s);
    apply(s);
    s.wbv = 0; s.wbrw = 0; s.wbm = 0;
    apply(s); apply(s);
    s.mdv = 1; s.md = 32'hBEEF;
    apply(s);

    // In-order returns of r1, r2, r3
    for (int i = 1; i <= 3; i++) begin
      s = idle(); ld_push(AW'(i), s); apply(s);
    end
    for (int i = 0; i < 3; i++) begin
      s = idle(); s.mdv = 1; s.md = 32'hA000 + DW'(i); apply(s);
    end
    s = idle(); apply(s);

    // Fill, stall a further load, overflow, then push+pop at full with wrap
    for (int i = 1; i <= 4; i++) begin
      s = idle(); ld_push(AW'(i), s); apply(s);
    end
    s = idle(); s.idv = 1; s.rw = 1; s.mtr = 1; s.rd = 9;
    apply(s);
    s = idle(); ld_push(8, s); apply(s);
    for (int i = 0; i < 3; i++) begin
      s = idle(); ld_push(AW'(10 + i), s); s.mdv = 1; s.md = DW'(i);
      s.idv = 1; s.rs = AW'(2 + i); s.rsu = 1; apply(s);
    end
    for (int i = 0; i < 5; i++) begin
      s = idle(); s.mdv = 1; s.md = 32'hC0DE + DW'(i); apply(s);
    end

    // WAW on r7
    s = idle(); ld_push(7, s); apply(s);
    s = idle(); s.idv = 1; s.rw = 1; s.rd = 7;
    apply(s); apply(s);
    s.mdv = 1; s.md = 32'h77; apply(s);
    s = idle(); apply(s);

    // Reset with two loads pending, then a return that must count as underflow
    s = idle(); ld_push(4, s); apply(s);
    s = idle(); ld_push(6, s); apply(s);
    s = idle(); s.rst = 1; s.idv = 1; s.rs = 4; s.rsu = 1; s.mdv = 1; apply(s);
    s = idle(); s.idv = 1; s.rs = 4; s.rsu = 1; s.rt = 6; s.rtu = 1; apply(s);
    s = idle(); s.mdv = 1; s.md = 32'hDEAD; apply(s);
    s = idle(); apply(s);

    for (int i = 0; i < 600; i++) begin
      s.rst   = ($urandom_range(0, 79) == 0);
      s.idv   = $urandom_range(0, 1); s.rsu = $urandom_range(0, 1);
      s.rtu   = $urandom_range(0, 1); s.rw = $urandom_range(0, 1);
      s.mtr   = ($urandom_range(0, 3) == 0);
      s.rs    = AW'($urandom_range(0, 7)); s.rt = AW'($urandom_range(0, 7));
      s.rd    = AW'($urandom_range(0, 7));
      s.rsd   = $urandom; s.rtd = $urandom;
      s.wbv   = $urandom_range(0, 1); s.wbrw = $urandom_range(0, 1);
      s.wbm   = $urandom_range(0, 1); s.wbrd = AW'($urandom_range(0, 7));
      s.wbres = $urandom;
      s.mdv   = ($urandom_range(0, 9) < 4); s.md = $urandom;
      apply(s);
    end
    s = idle(); apply(s);

    @(negedge clk);
    @(negedge clk);
    if (expq.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d entries left, want 0", expq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
